fpa_pipe: RTL



---
 rtl/fpa_pipe.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/fpa_pipe.sv
// fpa_pipe: pipelined floating-point add/subtract with valid/ready flow control.
// Stages: S1 unpack/swap/align, S2 mantissa add/sub, S3 normalise, then a
// registered pack/special-case output stage.

`ifndef EXP_SIZE
`define EXP_SIZE 8
`endif
`ifndef MANTIS_SIZE
`define MANTIS_SIZE 23
`endif

module fpa_pipe #(
    parameter int unsigned EXP_SIZE    = `EXP_SIZE,
    parameter int unsigned MANTIS_SIZE = `MANTIS_SIZE,
    parameter int unsigned TAG_WIDTH   = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [EXP_SIZE+MANTIS_SIZE:0]   in_a,
    input  logic [EXP_SIZE+MANTIS_SIZE:0]   in_b,
    input  logic                            in_op,
    input  logic [TAG_WIDTH-1:0]            in_tag,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [EXP_SIZE+MANTIS_SIZE:0]   out_result,
    output logic [TAG_WIDTH-1:0]            out_tag,
    output logic                            out_ovf,
    output logic                            out_zero
);

    // carry, hidden 1, fraction, 2 guard bits
    localparam int unsigned MW     = MANTIS_SIZE + 4;
    // signed exponent wide enough for normalisation over/underflow
    localparam int unsigned EW     = EXP_SIZE + 2;
    localparam int unsigned SH_LIM = MANTIS_SIZE + 3;
    localparam logic [EXP_SIZE-1:0] EXP_ONES = '1;

    logic adv;

    // whole pipeline moves only when the output slot is free or being drained
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // ---------------- S1: unpack, classify, swap, align ----------------
    logic                        a_s, b_s;
    logic [EXP_SIZE-1:0]         a_e, b_e;
    logic [MANTIS_SIZE-1:0]      a_f, b_f;
    logic                        a_zero, b_zero, a_inf, b_inf;
    logic [EXP_SIZE+MANTIS_SIZE-1:0] a_mag, b_mag;
    logic                        swap;
    logic                        x_s, x_zero, y_zero;
    logic [EXP_SIZE-1:0]         x_e, y_e, diff;
    logic [MANTIS_SIZE-1:0]      x_f, y_f;
    logic [MW-1:0]               mx, my, my_al;

    // operand decode and magnitude ordering so that |X| >= |Y|
    always_comb begin
        a_s    = in_a[EXP_SIZE+MANTIS_SIZE];
        b_s    = in_b[EXP_SIZE+MANTIS_SIZE] ^ in_op;
        a_e    = in_a[MANTIS_SIZE +: EXP_SIZE];
        b_e    = in_b[MANTIS_SIZE +: EXP_SIZE];
        a_f    = in_a[MANTIS_SIZE-1:0];
        b_f    = in_b[MANTIS_SIZE-1:0];
        a_zero = (a_e == '0);
        b_zero = (b_e == '0);
        a_inf  = (a_e == EXP_ONES);
        b_inf  = (b_e == EXP_ONES);
        a_mag  = a_zero ? '0 : {a_e, a_f};
        b_mag  = b_zero ? '0 : {b_e, b_f};
        swap   = (b_mag > a_mag);
        x_s    = swap ? b_s    : a_s;
        x_e    = swap ? b_e    : a_e;
        x_f    = swap ? b_f    : a_f;
        x_zero = swap ? b_zero : a_zero;
        y_e    = swap ? a_e    : b_e;
        y_f    = swap ? a_f    : b_f;
        y_zero = swap ? a_zero : b_zero;
        diff   = x_e - y_e;
        mx     = x_zero ? '0 : {2'b01, x_f, 2'b00};
        my     = y_zero ? '0 : {2'b01, y_f, 2'b00};
        my_al  = (32'(diff) >= SH_LIM) ? '0 : (my >> diff);
    end

    logic                   s1_valid, s1_sign, s1_sub, s1_inf, s1_nan, s1_inf_sign;
    logic [EXP_SIZE-1:0]    s1_exp;
    logic [MW-1:0]          s1_mx, s1_my;
    logic [TAG_WIDTH-1:0]   s1_tag;

    // S1 register: capture aligned operands on an input transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign     <= x_s;
                s1_sub      <= a_s ^ b_s;
                s1_exp      <= x_e;
                s1_mx       <= mx;
                s1_my       <= my_al;
                s1_inf      <= a_inf | b_inf;
                s1_nan      <= a_inf & b_inf & (a_s ^ b_s);
                s1_inf_sign <= a_inf ? a_s : b_s;
                s1_tag      <= in_tag;
            end
        end
    end

    // ---------------- S2: mantissa add/subtract ----------------
    logic                   s2_valid, s2_sign, s2_inf, s2_nan, s2_inf_sign;
    logic [EXP_SIZE-1:0]    s2_exp;
    logic [MW-1:0]          s2_sum;
    logic [TAG_WIDTH-1:0]   s2_tag;

    // S2 register: X is never smaller than Y, so the difference is non-negative
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sum      <= s1_sub ? (s1_mx - s1_my) : (s1_mx + s1_my);
                s2_sign     <= s1_sign;
                s2_exp      <= s1_exp;
                s2_inf      <= s1_inf;
                s2_nan      <= s1_nan;
                s2_inf_sign <= s1_inf_sign;
                s2_tag      <= s1_tag;
            end
        end
    end

    // ---------------- S3: normalise ----------------
    int unsigned                idx, lz;
    logic signed [EW-1:0]       n_exp;
    logic [MANTIS_SIZE-1:0]     n_frac;

    // leading-one search, shift and exponent adjust; guard bits truncated
    always_comb begin
        idx = 0;
        for (int unsigned i = 0; i < MW - 1; i++) begin
            if (s2_sum[i]) idx = i;
        end
        lz = (MW - 2) - idx;
        if (s2_sum[MW-1]) begin
            n_frac = MANTIS_SIZE'(s2_sum >> 3);
            n_exp  = $signed({2'b00, s2_exp} + EW'(1));
        end else begin
            n_frac = MANTIS_SIZE'((s2_sum << lz) >> 2);
            n_exp  = $signed({2'b00, s2_exp} - EW'(lz));
        end
    end

    logic                   s3_valid, s3_sign, s3_zero, s3_inf, s3_nan, s3_inf_sign;
    logic signed [EW-1:0]   s3_exp;
    logic [MANTIS_SIZE-1:0] s3_frac;
    logic [TAG_WIDTH-1:0]   s3_tag;

    // S3 register: normalised value plus special-case flags
    always_ff @(posedge clk) begin
        if (rst) begin
            s3_valid <= 1'b0;
        end else if (adv) begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                s3_sign     <= s2_sign;
                s3_exp      <= n_exp;
                s3_frac     <= n_frac;
                s3_zero     <= (s2_sum == '0);
                s3_inf      <= s2_inf;
                s3_nan      <= s2_nan;
                s3_inf_sign <= s2_inf_sign;
                s3_tag      <= s2_tag;
            end
        end
    end

    // ---------------- output: special cases and pack ----------------
    logic [EXP_SIZE+MANTIS_SIZE:0] res_c;
    logic                          ovf_c, zero_c;

    // special-case priority: inf-inf, infinity, zero, underflow, overflow
    always_comb begin
        res_c  = {s3_sign, s3_exp[EXP_SIZE-1:0], s3_frac};
        ovf_c  = 1'b0;
        zero_c = 1'b0;
        if (s3_nan) begin
            res_c = {1'b0, EXP_ONES, 1'b1, {(MANTIS_SIZE-1){1'b0}}};
        end else if (s3_inf) begin
            res_c = {s3_inf_sign, EXP_ONES, {MANTIS_SIZE{1'b0}}};
        end else if (s3_zero || (s3_exp <= $signed(EW'(0)))) begin
            res_c  = '0;
            zero_c = 1'b1;
        end else if (s3_exp >= $signed({2'b00, EXP_ONES})) begin
            res_c = {s3_sign, EXP_ONES, {MANTIS_SIZE{1'b0}}};
            ovf_c = 1'b1;
        end
    end

    // output register: holds while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            out_ovf    <= 1'b0;
            out_zero   <= 1'b0;
        end else if (adv) begin
            out_valid <= s3_valid;
            if (s3_valid) begin
                out_result <= res_c;
                out_tag    <= s3_tag;
                out_ovf    <= ovf_c;
                out_zero   <= zero_c;
            end
        end
    end

endmodule
